// File: rtl/uart_pkg.sv
// Shared sizing, defaults and helpers for the fractional baud-tick generator.
package uart_pkg;

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned FRAC_W       = 4;
    localparam int unsigned OSR          = 16;
    localparam int unsigned DEF_DIV_INT  = 27;
    localparam int unsigned DEF_DIV_FRAC = 2;
    localparam int unsigned DIV_W        = CNT_W + FRAC_W;

    // Divisor-reload handshake state: accepting, holding a shadow value, re-arming.
    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_PEND = 2'd1,
        CFG_DONE = 2'd2
    } cfg_state_e;

    // Fixed-point divisor as produced by calc_div.
    typedef struct packed {
        logic [CNT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } div_cfg_t;

    // Rounded {int, frac} divisor for a clock/baud/oversample combination.
    function automatic div_cfg_t calc_div(input longint unsigned clk_hz,
                                          input longint unsigned baud_hz,
                                          input longint unsigned osr);
        longint unsigned den;
        longint unsigned scaled;
        den      = baud_hz * osr;
        scaled   = ((clk_hz << FRAC_W) + (den >> 1)) / den;
        calc_div = div_cfg_t'(DIV_W'(scaled));
    endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Divisor reload handshake between a configuration master and the tick generator.
interface uart_baud_gen_frac_if #(
    parameter int unsigned CNT_W  = uart_pkg::CNT_W,
    parameter int unsigned FRAC_W = uart_pkg::FRAC_W
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div_int,
        output cfg_div_frac,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div_int,
        input  cfg_div_frac,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional period counter: emits a terminal-count pulse every div_int(+1) cycles,
// the +1 coming from the carry of a FRAC_W-bit phase accumulator.
module uart_frac_div #(
    parameter int unsigned CNT_W  = uart_pkg::CNT_W,
    parameter int unsigned FRAC_W = uart_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              clr_i,
    input  logic [CNT_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              term_c_o
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [CNT_W:0]    last_c;
    logic [FRAC_W:0]   sum_c;

    // Last count of this period, widened so the ext stretch cannot wrap.
    assign last_c   = {1'b0, div_int_i} - (CNT_W+1)'(1) + (CNT_W+1)'(ext_q);
    assign sum_c    = {1'b0, acc_q} + {1'b0, div_frac_i};
    assign term_c_o = enable_i & ({1'b0, cnt_q} == last_c);

    // Next-state: clear beats terminal count, which beats plain counting.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        ext_d = ext_q;
        if (clr_i) begin
            cnt_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
        end else if (term_c_o) begin
            cnt_d = '0;
            acc_d = sum_c[FRAC_W-1:0];
            ext_d = sum_c[FRAC_W];
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            ext_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            ext_q <= ext_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable fractional baud-tick generator with oversample, mid-bit and
// bit strobes, divisor reload over a valid/ready handshake and RX phase resync.
module uart_baud_gen_frac #(
    parameter int unsigned CNT_W        = uart_pkg::CNT_W,
    parameter int unsigned FRAC_W       = uart_pkg::FRAC_W,
    parameter int unsigned OSR          = uart_pkg::OSR,
    parameter int unsigned DEF_DIV_INT  = uart_pkg::DEF_DIV_INT,
    parameter int unsigned DEF_DIV_FRAC = uart_pkg::DEF_DIV_FRAC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       resync,
    uart_baud_gen_frac_if.slave        cfg,
    output logic                       tick,
    output logic                       mid_tick,
    output logic                       bit_tick,
    output logic [CNT_W-1:0]           act_div_int,
    output logic [FRAC_W-1:0]          act_div_frac
);

    import uart_pkg::*;

    localparam int unsigned OSR_W    = $clog2(OSR);
    localparam int unsigned OSR_MID  = OSR / 2 - 1;
    localparam int unsigned OSR_LAST = OSR - 1;

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic [CNT_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [OSR_W-1:0]  osr_q, osr_d;
    logic              tick_q, tick_d;
    logic              mid_q, mid_d;
    logic              bit_q, bit_d;
    logic              err_q, err_d;

    logic              xfer_c;
    logic              bad_c;
    logic              take_c;
    logic              apply_c;
    logic              term_c;

    // Handshake decode; a zero integer divisor is refused outright.
    assign xfer_c  = cfg.cfg_valid & (state_q == CFG_IDLE);
    assign bad_c   = xfer_c & (cfg.cfg_div_int == '0);
    assign take_c  = xfer_c & ~bad_c;
    // Shadow goes live at a period boundary, on resync, or whenever the core is frozen;
    // a transfer coinciding with resync bypasses the shadow entirely.
    assign apply_c = ((state_q == CFG_PEND) & (resync | ~enable | term_c)) | (take_c & resync);

    // Period/fraction core running on the active divisor.
    uart_frac_div #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (enable),
        .clr_i      (resync | apply_c),
        .div_int_i  (act_int_q),
        .div_frac_i (act_frac_q),
        .term_c_o   (term_c)
    );

    // Next-state for the handshake FSM, divisor registers, oversample phase and strobes.
    always_comb begin
        state_d    = state_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        osr_d      = osr_q;
        tick_d     = 1'b0;
        mid_d      = 1'b0;
        bit_d      = 1'b0;
        err_d      = bad_c;

        case (state_q)
            CFG_IDLE: if (take_c && !resync) state_d = CFG_PEND;
            CFG_PEND: if (apply_c)           state_d = CFG_DONE;
            CFG_DONE:                        state_d = CFG_IDLE;
            default:                         state_d = CFG_IDLE;
        endcase

        if (take_c) begin
            shd_int_d  = cfg.cfg_div_int;
            shd_frac_d = cfg.cfg_div_frac;
        end

        if (take_c && resync) begin
            act_int_d  = cfg.cfg_div_int;
            act_frac_d = cfg.cfg_div_frac;
        end else if (apply_c) begin
            act_int_d  = shd_int_q;
            act_frac_d = shd_frac_q;
        end

        if (resync) begin
            osr_d = '0;
        end else if (term_c) begin
            osr_d  = osr_q + OSR_W'(1);
            tick_d = 1'b1;
            mid_d  = (osr_q == OSR_W'(OSR_MID));
            bit_d  = (osr_q == OSR_W'(OSR_LAST));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CFG_IDLE;
            shd_int_q  <= '0;
            shd_frac_q <= '0;
            act_int_q  <= CNT_W'(DEF_DIV_INT);
            act_frac_q <= FRAC_W'(DEF_DIV_FRAC);
            osr_q      <= '0;
            tick_q     <= 1'b0;
            mid_q      <= 1'b0;
            bit_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            osr_q      <= osr_d;
            tick_q     <= tick_d;
            mid_q      <= mid_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
        end
    end

    assign cfg.cfg_ready = (state_q == CFG_IDLE);
    assign cfg.cfg_err   = err_q;
    assign tick          = tick_q;
    assign mid_tick      = mid_q;
    assign bit_tick      = bit_q;
    assign act_div_int   = act_int_q;
    assign act_div_frac  = act_frac_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: rates, fraction pattern, handshake, resync,
// enable freeze and reset with a pending reload.
module tb_uart_baud_gen_frac;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        resync = 1'b0;
    logic        tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [15:0] act_div_int;
    logic [3:0]  act_div_frac;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    uart_baud_gen_frac_if #(.CNT_W(16), .FRAC_W(4)) cfg_if ();

    uart_baud_gen_frac #(
        .CNT_W(16), .FRAC_W(4), .OSR(16), .DEF_DIV_INT(27), .DEF_DIV_FRAC(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .resync       (resync),
        .cfg          (cfg_if),
        .tick         (tick),
        .mid_tick     (mid_tick),
        .bit_tick     (bit_tick),
        .act_div_int  (act_div_int),
        .act_div_frac (act_div_frac)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wait (bounded) for a strobe: 0 tick, 1 mid_tick, 2 bit_tick; returns cycle stamp.
    task automatic wait_ev(input int which, input int budget, input string name, output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = tick;
                1:       seen = mid_tick;
                default: seen = bit_tick;
            endcase
            if (seen) t = cyc;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no strobe within %0d cycles", name, budget);
        end
    endtask

    // Present a divisor for one cycle starting at the current negedge.
    task automatic offer(input logic [15:0] di, input logic [3:0] df);
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_div_int  = di;
        cfg_if.cfg_div_frac = df;
        @(negedge clk);
        cfg_if.cfg_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (tick !== 1'b0)      begin n_err++; $display("FAIL rst_tick: got %b want 0", tick); end
        n_vec++; if (mid_tick !== 1'b0)  begin n_err++; $display("FAIL rst_mid: got %b want 0", mid_tick); end
        n_vec++; if (bit_tick !== 1'b0)  begin n_err++; $display("FAIL rst_bit: got %b want 0", bit_tick); end
        n_vec++; if (cfg_if.cfg_err !== 1'b0)   begin n_err++; $display("FAIL rst_err: got %b want 0", cfg_if.cfg_err); end
        n_vec++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cfg_if.cfg_ready); end
        n_vec++; if (act_div_int !== 16'd27) begin n_err++; $display("FAIL rst_int: got %0d want 27", act_div_int); end
        n_vec++; if (act_div_frac !== 4'd2)  begin n_err++; $display("FAIL rst_frac: got %0d want 2", act_div_frac); end
    endtask

    task automatic test_default_rate();
        int c0, tb1, tb2, tm;
        int tt [0:16];
        int exp_iv [1:8] = '{27, 27, 27, 27, 27, 27, 27, 28};
        enable = 1'b1;
        reset  = 1'b0;
        c0     = cyc;
        wait_ev(0, 100, "def_first", tt[0]);
        n_vec++; if (tt[0] - c0 != 27) begin n_err++; $display("FAIL def_first_lat: got %0d want 27", tt[0] - c0); end
        for (int k = 1; k <= 16; k++) wait_ev(0, 40, "def_tick", tt[k]);
        for (int k = 1; k <= 8; k++) begin
            n_vec++;
            if (tt[k] - tt[k-1] != exp_iv[k]) begin
                n_err++; $display("FAIL def_period%0d: got %0d want %0d", k, tt[k] - tt[k-1], exp_iv[k]);
            end
        end
        n_vec++; if (tt[16] - tt[0] != 434) begin n_err++; $display("FAIL def_sum16: got %0d want 434", tt[16] - tt[0]); end
        wait_ev(2, 600, "def_bit1", tb1);
        wait_ev(2, 600, "def_bit2", tb2);
        n_vec++; if (tb2 - tb1 != 434) begin n_err++; $display("FAIL def_bit_period: got %0d want 434", tb2 - tb1); end
        wait_ev(1, 600, "def_mid", tm);
        n_vec++;
        if (tm - tb2 < 216 || tm - tb2 > 218) begin
            n_err++; $display("FAIL def_mid_offset: got %0d want 217+-1", tm - tb2);
        end
    endtask

    task automatic test_handshake();
        int t0, t1, t2;
        wait_ev(0, 100, "hs_sync", t0);
        repeat (5) @(negedge clk);
        n_vec++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_pre: got %b want 1", cfg_if.cfg_ready); end
        offer(16'd10, 4'd0);
        n_vec++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_drop: got %b want 0", cfg_if.cfg_ready); end
        n_vec++; if (act_div_int !== 16'd27)    begin n_err++; $display("FAIL hs_int_hold: got %0d want 27", act_div_int); end
        wait_ev(0, 100, "hs_apply", t1);
        n_vec++; if (t1 - t0 != 27 && t1 - t0 != 28) begin n_err++; $display("FAIL hs_old_period: got %0d want 27 or 28", t1 - t0); end
        n_vec++; if (act_div_int !== 16'd10)    begin n_err++; $display("FAIL hs_int_new: got %0d want 10", act_div_int); end
        n_vec++; if (act_div_frac !== 4'd0)     begin n_err++; $display("FAIL hs_frac_new: got %0d want 0", act_div_frac); end
        n_vec++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_apply: got %b want 0", cfg_if.cfg_ready); end
        @(negedge clk);
        n_vec++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_back: got %b want 1", cfg_if.cfg_ready); end
        wait_ev(0, 40, "hs_next", t2);
        n_vec++; if (t2 - t1 != 10) begin n_err++; $display("FAIL hs_new_period: got %0d want 10", t2 - t1); end
    endtask

    task automatic test_cfg_err();
        offer(16'd0, 4'd3);
        n_vec++; if (cfg_if.cfg_err !== 1'b1)   begin n_err++; $display("FAIL err_pulse: got %b want 1", cfg_if.cfg_err); end
        n_vec++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL err_ready: got %b want 1", cfg_if.cfg_ready); end
        @(negedge clk);
        n_vec++; if (cfg_if.cfg_err !== 1'b0)   begin n_err++; $display("FAIL err_width: got %b want 0", cfg_if.cfg_err); end
        n_vec++; if (act_div_int !== 16'd10)    begin n_err++; $display("FAIL err_int: got %0d want 10", act_div_int); end
        n_vec++; if (act_div_frac !== 4'd0)     begin n_err++; $display("FAIL err_frac: got %0d want 0", act_div_frac); end
    endtask

    task automatic test_int4();
        int ts, tp, tn, tb1, tb2, tm;
        wait_ev(0, 40, "i4_sync", ts);
        offer(16'd4, 4'd0);
        wait_ev(0, 40, "i4_apply", tp);
        n_vec++; if (act_div_int !== 16'd4) begin n_err++; $display("FAIL i4_int: got %0d want 4", act_div_int); end
        for (int k = 0; k < 4; k++) begin
            wait_ev(0, 20, "i4_tick", tn);
            n_vec++; if (tn - tp != 4) begin n_err++; $display("FAIL i4_period%0d: got %0d want 4", k, tn - tp); end
            tp = tn;
        end
        wait_ev(2, 100, "i4_bit1", tb1);
        wait_ev(2, 100, "i4_bit2", tb2);
        n_vec++; if (tb2 - tb1 != 64) begin n_err++; $display("FAIL i4_bit_period: got %0d want 64", tb2 - tb1); end
        wait_ev(1, 100, "i4_mid", tm);
        n_vec++; if (tm - tb2 != 32) begin n_err++; $display("FAIL i4_mid_offset: got %0d want 32", tm - tb2); end
    endtask

    task automatic test_frac();
        int ts;
        int tt [0:32];
        int exp_iv [1:6] = '{4, 4, 5, 4, 5, 4};
        wait_ev(0, 20, "fr_sync", ts);
        offer(16'd4, 4'd8);
        wait_ev(0, 20, "fr_apply", tt[0]);
        n_vec++; if (act_div_frac !== 4'd8) begin n_err++; $display("FAIL fr_frac: got %0d want 8", act_div_frac); end
        for (int k = 1; k <= 32; k++) wait_ev(0, 20, "fr_tick", tt[k]);
        for (int k = 1; k <= 6; k++) begin
            n_vec++;
            if (tt[k] - tt[k-1] != exp_iv[k]) begin
                n_err++; $display("FAIL fr_period%0d: got %0d want %0d", k, tt[k] - tt[k-1], exp_iv[k]);
            end
        end
        n_vec++; if (tt[32] - tt[0] != 143) begin n_err++; $display("FAIL fr_sum32: got %0d want 143", tt[32] - tt[0]); end
    endtask

    task automatic test_int1();
        int ts, tp;
        int misses;
        wait_ev(0, 20, "i1_sync", ts);
        offer(16'd1, 4'd0);
        wait_ev(0, 20, "i1_apply", tp);
        n_vec++; if (act_div_int !== 16'd1) begin n_err++; $display("FAIL i1_int: got %0d want 1", act_div_int); end
        misses = 0;
        repeat (6) begin
            @(negedge clk);
            if (tick !== 1'b1) misses++;
        end
        n_vec++; if (misses != 0) begin n_err++; $display("FAIL i1_every_cycle: got %0d idle cycles want 0", misses); end
    endtask

    task automatic test_resync();
        int tr, t, tb, tn, trs;
        // Reload combined with resync while ticking every cycle.
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_div_int  = 16'd6;
        cfg_if.cfg_div_frac = 4'd0;
        resync              = 1'b1;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        resync           = 1'b0;
        tr               = cyc;
        n_vec++; if (tick !== 1'b0)             begin n_err++; $display("FAIL rs_cfg_notick: got %b want 0", tick); end
        n_vec++; if (act_div_int !== 16'd6)     begin n_err++; $display("FAIL rs_cfg_int: got %0d want 6", act_div_int); end
        n_vec++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rs_cfg_ready: got %b want 1", cfg_if.cfg_ready); end
        wait_ev(0, 20, "rs_cfg_tick", t);
        n_vec++; if (t - tr != 6) begin n_err++; $display("FAIL rs_cfg_lat: got %0d want 6", t - tr); end
        wait_ev(2, 200, "rs_cfg_bit", tb);
        n_vec++; if (tb - tr != 96) begin n_err++; $display("FAIL rs_cfg_bit: got %0d want 96", tb - tr); end
        // Resync landing on the terminal-count cycle.
        wait_ev(0, 20, "rs_sync", tn);
        repeat (5) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        trs    = cyc;
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL rs_tc_notick: got %b want 0", tick); end
        wait_ev(0, 20, "rs_tc_tick", t);
        n_vec++; if (t - trs != 6) begin n_err++; $display("FAIL rs_tc_lat: got %0d want 6", t - trs); end
        wait_ev(2, 200, "rs_tc_bit", tb);
        n_vec++; if (tb - trs != 96) begin n_err++; $display("FAIL rs_tc_bit: got %0d want 96", tb - trs); end
    endtask

    task automatic test_enable();
        int tn, t;
        int stray;
        wait_ev(0, 20, "en_sync", tn);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        stray  = 0;
        repeat (7) begin
            @(negedge clk);
            if (tick !== 1'b0 || mid_tick !== 1'b0 || bit_tick !== 1'b0) stray++;
        end
        enable = 1'b1;
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL en_frozen_strobes: got %0d want 0", stray); end
        wait_ev(0, 30, "en_tick", t);
        n_vec++; if (t - tn != 13) begin n_err++; $display("FAIL en_delay: got %0d want 13", t - tn); end
    endtask

    task automatic test_reset_pending();
        int tn, c0, t1, t2;
        wait_ev(0, 20, "rp_sync", tn);
        repeat (2) @(negedge clk);
        offer(16'd9, 4'd5);
        n_vec++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL rp_pending: got %b want 0", cfg_if.cfg_ready); end
        #2 reset = 1'b1;
        @(negedge clk);
        n_vec++; if (act_div_int !== 16'd27)    begin n_err++; $display("FAIL rp_int: got %0d want 27", act_div_int); end
        n_vec++; if (act_div_frac !== 4'd2)     begin n_err++; $display("FAIL rp_frac: got %0d want 2", act_div_frac); end
        n_vec++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rp_ready: got %b want 1", cfg_if.cfg_ready); end
        n_vec++; if (tick !== 1'b0)             begin n_err++; $display("FAIL rp_tick: got %b want 0", tick); end
        reset = 1'b0;
        c0    = cyc;
        wait_ev(0, 100, "rp_first", t1);
        n_vec++; if (t1 - c0 != 27)          begin n_err++; $display("FAIL rp_first_lat: got %0d want 27", t1 - c0); end
        wait_ev(0, 100, "rp_second", t2);
        n_vec++; if (t2 - t1 != 27)          begin n_err++; $display("FAIL rp_period: got %0d want 27", t2 - t1); end
        n_vec++; if (act_div_int !== 16'd27) begin n_err++; $display("FAIL rp_no_apply: got %0d want 27", act_div_int); end
    endtask

    initial begin
        cfg_if.cfg_valid    = 1'b0;
        cfg_if.cfg_div_int  = '0;
        cfg_if.cfg_div_frac = '0;
        test_reset();
        test_default_rate();
        test_handshake();
        test_cfg_err();
        test_int4();
        test_frac();
        test_int1();
        test_resync();
        test_enable();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
